addsub_multicycle: RTL and testbench
====================================

// Module: addsub_multicycle
// PURPOSE
//  Parametrised multi-precision two's-complement add/subtract unit. Processes WIDTH-bit
//  operands serially in LIMB-bit slices with a registered inter-limb carry. Reports
//  carry, overflow, zero and negative flags. Uses valid/ready handshakes on input and output.
//  Sits between the operand register file and the writeback stage of the datapath.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of LIMB
//  LIMB   8   bits processed per CALC cycle; NLIMB = WIDTH/LIMB (derived localparam, >=1)
// PORTS
//  clk_i     in   1      clock, rising edge
//  rst_i     in   1      asynchronous, active-high reset
//  valid_i   in   1      operand/op valid
//  ready_o   out  1      unit can accept an operation
//  a_i       in   WIDTH  operand A
//  b_i       in   WIDTH  operand B
//  add_sub_i in   1      0 = A+B, 1 = A-B
//  valid_o   out  1      result and flags valid
//  ready_i   in   1      consumer accepts result
//  result_o  out  WIDTH  result
//  cout_o    out  1      carry out of MSB (subtraction: 1 = no borrow)
//  ovf_o     out  1      signed overflow
//  zero_o    out  1      result_o == 0
//  neg_o     out  1      result_o[WIDTH-1]
// BEHAVIOUR
//  - Reset (async): state=IDLE; ready_o=1; valid_o=0; result_o=0; all flags=0; limb index=0.
//    Reset mid-operation discards the operation. valid_o falls immediately.
//  - FSM states: IDLE, CALC, DONE. ready_o = (state==IDLE). valid_o = (state==DONE).
//  - IDLE: on valid_i&&ready_o, latch a_i, b_i ^ {WIDTH{add_sub_i}} and op; carry<=add_sub_i;
//    idx<=0; go to CALC. valid_i while not ready_o is ignored.
//  - CALC, each cycle: {c,s} = a[idx] + bx[idx] + carry (LIMB+1 bits); write limb idx of the
//    result register; carry<=c; idx<=idx+1. After limb NLIMB-1, go to DONE.
//  - Flags in DONE: cout_o = final carry. ovf_o = (a_msb==bx_msb) && (sum_msb!=a_msb).
//    zero_o and neg_o are computed on the final result_o, after saturation.
//  - DONE: outputs held stable until ready_i is high. On ready_i, go to IDLE. valid_o drops
//    the next cycle.
//  - Latency: valid_o rises NLIMB+1 edges after the accept edge. Minimum issue interval is
//    NLIMB+2 cycles. With NLIMB==1, CALC lasts one cycle.
//  - Latched operands are used throughout, so a_i/b_i/add_sub_i may change after the accept.
//  - Wrap-around: result is modulo 2^WIDTH unless saturation is enabled.
// CONFIGURATION
//  ADDSUB_SAT_EN defined: when ovf is detected, result_o saturates.
//    A non-negative A gives 0111..1. A negative A gives 1000..0. ovf_o still reads 1 and
//    cout_o is unchanged.
//  ADDSUB_SAT_EN undefined: result_o is the wrapped sum. No saturation logic is built.
// STRUCTURE
//  - Package addsub_pkg: typedef enum logic [1:0] {IDLE,CALC,DONE} addsub_state_t;
//    localparam ADD=1'b0, SUB=1'b1.
//  - Sub-module addsub_limb (LIMB param): combinational a+b+cin -> {cout, sum, msb taps}.
//    Instantiated once and time-multiplexed by idx.
// TESTING (WIDTH=16, LIMB=8, ready_i=1 unless stated)
//  1. add 0x00FF+0x0001 -> result 0x0100, cout 0, ovf 0. valid_o exactly 3 edges after accept.
//  2. add 0x4600+0x4600 -> 0x8C00, ovf 1, neg 1, cout 0. With ADDSUB_SAT_EN: 0x7FFF, neg 0.
//  3. sub 0x0008-0x0003 -> 0x0005, cout 1, ovf 0. sub 0x0005-0x000A -> 0xFFFB, cout 0, neg 1.
//  4. sub 0x1234-0x1234 -> 0x0000, zero 1, cout 1. add 0xBA00+0xBA00 -> 0x7400, cout 1, ovf 1.
//     With ADDSUB_SAT_EN: 0x8000.
//  5. Hold ready_i=0 for 5 cycles in DONE -> outputs/flags constant, ready_o 0, valid_i pulses
//     ignored. Release -> IDLE next cycle.
//  6. Assert rst_i during CALC -> valid_o/result_o/flags 0 with no clock edge. After release,
//     ready_o 1 and a new op completes correctly.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the multi-limb add/subtract unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/addsub_limb.sv
// One LIMB-bit slice of the adder: a + b + cin, with MSB taps for overflow detection.
module addsub_limb #(
    parameter int LIMB = 8
) (
    input  logic [LIMB-1:0] a_i,
    input  logic [LIMB-1:0] b_i,
    input  logic            cin_i,
    output logic [LIMB-1:0] sum_o,
    output logic            cout_o,
    output logic            a_msb_o,
    output logic            b_msb_o,
    output logic            s_msb_o
);

    always_comb begin
        {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{LIMB{1'b0}}, cin_i};
        a_msb_o = a_i[LIMB-1];
        b_msb_o = b_i[LIMB-1];
        s_msb_o = sum_o[LIMB-1];
    end

endmodule

// File: rtl/addsub_multicycle.sv
// Serial multi-precision add/subtract, one LIMB per cycle with registered inter-limb carry.
// Optional build macro ADDSUB_SAT_EN enables saturation of the result on signed overflow.
module addsub_multicycle
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LIMB  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             add_sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o
);

    localparam int NLIMB = WIDTH / LIMB;
    localparam int IDXW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NLIMB - 1);

    addsub_state_t    state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [LIMB-1:0]  limb_a, limb_b, limb_sum;
    logic             limb_cout, limb_a_msb, limb_b_msb, limb_s_msb;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] res_final;
    logic             ovf_next;

`ifdef ADDSUB_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(input logic a_neg);
        return a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    assign limb_a = a_q[int'(idx_q)*LIMB +: LIMB];
    assign limb_b = bx_q[int'(idx_q)*LIMB +: LIMB];

    addsub_limb #(.LIMB(LIMB)) u_limb (
        .a_i     (limb_a),
        .b_i     (limb_b),
        .cin_i   (carry_q),
        .sum_o   (limb_sum),
        .cout_o  (limb_cout),
        .a_msb_o (limb_a_msb),
        .b_msb_o (limb_b_msb),
        .s_msb_o (limb_s_msb)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            bx_q    <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = CALC;
            CALC:    if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        bx_d     = bx_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        res_d    = res_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        res_next = res_q;
        res_next[int'(idx_q)*LIMB +: LIMB] = limb_sum;
        // Overflow only matters on the top limb, where the MSB taps are the word's sign bits.
        ovf_next = (limb_a_msb == limb_b_msb) && (limb_s_msb != limb_a_msb);
`ifdef ADDSUB_SAT_EN
        res_final = ovf_next ? saturate(limb_a_msb) : res_next;
`else
        res_final = res_next;
`endif
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = a_i;
                    bx_d    = b_i ^ {WIDTH{add_sub_i == SUB}};
                    carry_d = (add_sub_i == SUB);
                    idx_d   = '0;
                end
            end
            CALC: begin
                carry_d = limb_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    res_d  = res_final;
                    cout_d = limb_cout;
                    ovf_d  = ovf_next;
                    zero_d = (res_final == '0);
                    neg_d  = res_final[WIDTH-1];
                end else begin
                    idx_d = idx_q + 1'b1;
                    res_d = res_next;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready_o  = (state_q == IDLE);
        valid_o  = (state_q == DONE);
        result_o = res_q;
        cout_o   = cout_q;
        ovf_o    = ovf_q;
        zero_o   = zero_q;
        neg_o    = neg_q;
    end

endmodule

// File: tb/tb_addsub_multicycle.sv
// Directed bench for addsub_multicycle at WIDTH=16, LIMB=8; define ADDSUB_SAT_EN to check saturation.
module tb_addsub_multicycle;

    localparam int W = 16;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         add_sub_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [W-1:0] result_o;
    logic         cout_o, ovf_o, zero_o, neg_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } vec_t;

    vec_t vecs[9];

    addsub_multicycle #(.WIDTH(16), .LIMB(8)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .add_sub_i (add_sub_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .cout_o    (cout_o),
        .ovf_o     (ovf_o),
        .zero_o    (zero_o),
        .neg_o     (neg_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        int t;
        t = 0;
        @(negedge clk_i);
        while (!ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        chk("ready_before_issue", {31'd0, ready_o}, 32'd1);
        a_i = a;
        b_i = b;
        add_sub_i = op;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        a_i = 16'hDEAD;
        b_i = 16'hBEEF;
        add_sub_i = ~op;
    endtask

    // lat counts edges from the accept edge inclusive until valid_o is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!valid_o && lat < 50) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic chk_outputs(input string tag, input vec_t v);
        chk({tag, "_result"}, {16'd0, result_o}, {16'd0, v.res});
        chk({tag, "_cout"}, {31'd0, cout_o}, {31'd0, v.cout});
        chk({tag, "_ovf"}, {31'd0, ovf_o}, {31'd0, v.ovf});
        chk({tag, "_zero"}, {31'd0, zero_o}, {31'd0, v.zero});
        chk({tag, "_neg"}, {31'd0, neg_o}, {31'd0, v.neg});
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        start_op(v.a, v.b, v.op);
        wait_done(lat);
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        chk_outputs(tag, v);
        @(posedge clk_i);
        #1;
        chk({tag, "_valid_drop"}, {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        vec_t hold_v;
        vec_t post_v;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SAT_EN
        vecs[1] = '{16'h4600, 16'h4600, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'hBA00, 16'hBA00, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        vecs[1] = '{16'h4600, 16'h4600, 1'b0, 16'h8C00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'hBA00, 16'hBA00, 1'b0, 16'h7400, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        vecs[2] = '{16'h0008, 16'h0003, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h000A, 1'b1, 16'hFFFB, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state, before any clock edge.
        #1;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk_outputs("rst", '{16'h0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-pressure: result held while ready_i is low; new requests ignored.
        hold_v = vecs[3];
        ready_i = 1'b0;
        run_vec_hold: begin
            int lat;
            start_op(hold_v.a, hold_v.b, hold_v.op);
            wait_done(lat);
            chk("hold_latency", lat, 3);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk_i);
                valid_i = 1'b1;
                a_i = 16'h0101 * 16'(c + 1);
                b_i = 16'h0011;
                add_sub_i = 1'b0;
                @(posedge clk_i);
                #1;
                chk($sformatf("hold%0d_valid", c), {31'd0, valid_o}, 32'd1);
                chk($sformatf("hold%0d_ready", c), {31'd0, ready_o}, 32'd0);
                chk_outputs($sformatf("hold%0d", c), hold_v);
            end
            @(negedge clk_i);
            valid_i = 1'b0;
            ready_i = 1'b1;
            @(posedge clk_i);
            #1;
            chk("release_valid", {31'd0, valid_o}, 32'd0);
            chk("release_ready", {31'd0, ready_o}, 32'd1);
        end

        // Asynchronous reset in the middle of CALC.
        start_op(16'h4600, 16'h4600, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, valid_o}, 32'd0);
        chk("midrst_ready", {31'd0, ready_o}, 32'd1);
        chk_outputs("midrst", '{16'h0, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("postrst_ready", {31'd0, ready_o}, 32'd1);
        post_v = vecs[2];
        run_vec("postrst", post_v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
